// File: rtl/mdr_mem_responder.sv
// Memory-side responder for the MAR/MDR port: a single-port synchronous RAM
// behind a small IDLE/WAIT/DONE handshake with a fixed number of wait states.
module mdr_mem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       MAR_in,
  input  logic [DATA_W-1:0] MDR_in,
  output logic [DATA_W-1:0] Mdatain,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int          DEPTH   = 1 << ADDR_W;
  localparam logic [3:0]  LP_WAIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_next;
  logic                r_op_wr;
  logic                w_op_wr_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_addr_next;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   w_wdata_next;
  logic                r_err;
  logic                w_err_next;
  logic [DATA_W-1:0]   r_rdata;
  logic                w_commit;
  logic                w_ram_we;
  logic                w_ram_re;

  logic [DATA_W-1:0]   r_ram [DEPTH];

  // Upper MAR bits are deliberately ignored so addresses alias modulo the depth.
  logic                w_unused_mar;
  assign w_unused_mar = &{1'b0, MAR_in[31:ADDR_W]};

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op_wr <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_op_wr <= w_op_wr_next;
      r_addr  <= w_addr_next;
      r_wdata <= w_wdata_next;
      r_err   <= w_err_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_op_wr_next = r_op_wr;
    w_addr_next  = r_addr;
    w_wdata_next = r_wdata;
    w_err_next   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (read ^ write) begin
          w_op_wr_next = write;
          w_addr_next  = MAR_in[ADDR_W-1:0];
          w_wdata_next = MDR_in;
          w_cnt_next   = LP_WAIT;
          w_state_next = (LP_WAIT == 4'd0) ? S_DONE : S_WAIT;
        end else if (read && write) begin
          w_err_next = 1'b1;
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // The RAM access happens on the edge that enters DONE; with zero wait states
  // that is the accept edge itself, hence the use of the *_next values.
  assign w_commit = (w_state_next == S_DONE) && !clr;
  assign w_ram_we = w_commit && w_op_wr_next;
  assign w_ram_re = w_commit && !w_op_wr_next;

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_ram[w_addr_next] <= w_wdata_next;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_rdata <= '0;
    end else if (w_ram_re) begin
      r_rdata <= r_ram[w_addr_next];
    end
  end

  assign Mdatain = r_rdata;
  assign busy    = (r_state == S_WAIT);
  assign done    = (r_state == S_DONE);
  assign err     = r_err;

endmodule

// File: tb/tb_mdr_mem_responder.sv
// Directed bench for mdr_mem_responder: one instance with two wait states and
// one with zero wait states, sharing clock and reset.
module tb_mdr_mem_responder;

  logic        clk = 1'b0;
  logic        clr;
  logic        read, write;
  logic [31:0] MAR_in, MDR_in, Mdatain;
  logic        busy, done, err;

  logic        z_read, z_write;
  logic [31:0] z_MAR_in, z_MDR_in, z_Mdatain;
  logic        z_busy, z_done, z_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mdr_mem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_STATES(2)) dut (
    .clk(clk), .clr(clr), .read(read), .write(write), .MAR_in(MAR_in),
    .MDR_in(MDR_in), .Mdatain(Mdatain), .busy(busy), .done(done), .err(err)
  );

  mdr_mem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_STATES(0)) dut0 (
    .clk(clk), .clr(clr), .read(z_read), .write(z_write), .MAR_in(z_MAR_in),
    .MDR_in(z_MDR_in), .Mdatain(z_Mdatain), .busy(z_busy), .done(z_done), .err(z_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One request on the 2-wait-state instance, accept edge is the next posedge.
  // MAR_in is switched to mar_after right after acceptance to prove latching.
  task automatic op2(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] mar_after, input logic [31:0] exp, input string nm);
    int lat;
    int busy_cnt;
    bit found;
    read = !wr; write = wr; MAR_in = addr; MDR_in = wd;
    step();
    read = 0; write = 0; MAR_in = mar_after; MDR_in = 32'h0BAD_0BAD;
    lat = 0; busy_cnt = 0; found = 0;
    for (int c = 1; c <= 8 && !found; c++) begin
      lat = c;
      if (done === 1'b1) found = 1;
      else begin
        if (busy === 1'b1) busy_cnt++;
        step();
      end
    end
    chk({nm, " latency"}, lat, 3);
    chk({nm, " busy cycles"}, busy_cnt, 2);
    chk({nm, " busy in done"}, {31'b0, busy}, 0);
    if (!wr) chk({nm, " Mdatain"}, Mdatain, exp);
    $display("op %s wr=%0d addr=%h lat=%0d busy=%0d Mdatain=%h", nm, wr, addr, lat, busy_cnt, Mdatain);
    step();
    chk({nm, " done falls"}, {31'b0, done}, 0);
  endtask

  task automatic test_reset();
    clr = 1; read = 0; write = 0; MAR_in = 0; MDR_in = 0;
    z_read = 0; z_write = 0; z_MAR_in = 0; z_MDR_in = 0;
    step(); step();
    clr = 0;
    step();
    chk("reset busy", {31'b0, busy}, 0);
    chk("reset done", {31'b0, done}, 0);
    chk("reset err", {31'b0, err}, 0);
    chk("reset Mdatain", Mdatain, 0);
    chk("reset z_Mdatain", z_Mdatain, 0);
    $display("reset: busy=%0d done=%0d err=%0d Mdatain=%h", busy, done, err, Mdatain);
  endtask

  task automatic test_write_read();
    op2(1, 5, 32'hDEADBEEF, 5, 0, "wr5");
    op2(0, 5, 0, 5, 32'hDEADBEEF, "rd5");
  endtask

  task automatic test_zero_wait();
    z_write = 1; z_MAR_in = 0; z_MDR_in = 32'h1;
    step();
    z_write = 0; z_MDR_in = 32'hFFFF_FFFF;
    chk("zw write done", {31'b0, z_done}, 1);
    chk("zw write busy", {31'b0, z_busy}, 0);
    step();
    chk("zw write idle", {31'b0, z_done}, 0);
    z_read = 1;
    step();
    z_read = 0;
    chk("zw read done", {31'b0, z_done}, 1);
    chk("zw read Mdatain", z_Mdatain, 32'h1);
    $display("zero-wait read addr 0: done=%0d Mdatain=%h", z_done, z_Mdatain);
    step();
    chk("zw read idle", {31'b0, z_done}, 0);
  endtask

  task automatic test_conflict();
    op2(1, 7, 32'h0000_0077, 7, 0, "wr7");
    read = 1; write = 1; MAR_in = 7; MDR_in = 32'h55;
    step();
    read = 0; write = 0;
    chk("conflict err", {31'b0, err}, 1);
    chk("conflict busy", {31'b0, busy}, 0);
    chk("conflict done", {31'b0, done}, 0);
    step();
    chk("conflict err pulse", {31'b0, err}, 0);
    chk("conflict busy2", {31'b0, busy}, 0);
    chk("conflict done2", {31'b0, done}, 0);
    $display("conflict: err pulse seen, then read back addr 7");
    op2(0, 7, 0, 7, 32'h0000_0077, "rd7");
  endtask

  task automatic test_alias_latch();
    op2(1, 32'h10, 32'h1010_1010, 32'h10, 0, "wr10");
    op2(1, 3, 32'hA5A5A5A5, 3, 0, "wr3");
    op2(0, 32'h203, 0, 32'h10, 32'hA5A5A5A5, "rd203");
  endtask

  task automatic test_abort();
    op2(1, 9, 32'hCAFE_0009, 9, 0, "wr9");
    write = 1; MAR_in = 9; MDR_in = 32'h1234;
    step();
    write = 0;
    step();
    clr = 1;
    step();
    clr = 0;
    chk("abort done", {31'b0, done}, 0);
    chk("abort busy", {31'b0, busy}, 0);
    chk("abort Mdatain", Mdatain, 0);
    step();
    chk("abort done2", {31'b0, done}, 0);
    $display("abort: done=%0d busy=%0d Mdatain=%h", done, busy, Mdatain);
    op2(0, 9, 0, 9, 32'hCAFE_0009, "rd9");
  endtask

  task automatic test_back_to_back();
    read = 1; MAR_in = 5;
    for (int c = 1; c <= 16; c++) begin
      step();
      chk($sformatf("b2b done c%0d", c), {31'b0, done}, {31'b0, (c % 4) == 3});
      chk($sformatf("b2b busy c%0d", c), {31'b0, busy}, {31'b0, (c % 4) == 1 || (c % 4) == 2});
      if (done === 1'b1) chk($sformatf("b2b Mdatain c%0d", c), Mdatain, 32'hDEADBEEF);
      $display("b2b cycle %0d: busy=%0d done=%0d Mdatain=%h", c, busy, done, Mdatain);
    end
    read = 0;
    step();
    chk("b2b quiet", {31'b0, busy}, 0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_wait();
    test_conflict();
    test_alias_latch();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
